// File: rtl/am2940_pkg.sv
// rtl/am2940_pkg.sv - shared am2940 instruction codes, DMA controller states and width default.
// The REINIT state exists only when AM2940_DMA_AUTO_REINIT_EN is defined.
package am2940_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [2:0] WRCR   = 3'b000;
  localparam logic [2:0] RDCR   = 3'b001;
  localparam logic [2:0] RDWC   = 3'b010;
  localparam logic [2:0] RDAC   = 3'b011;
  localparam logic [2:0] REINIT = 3'b100;
  localparam logic [2:0] LDAD   = 3'b101;
  localparam logic [2:0] LDWC   = 3'b110;
  localparam logic [2:0] ENCT   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CR,
    S_LD_ADDR,
    S_LD_WC,
    S_XFER,
    S_FIN
`ifdef AM2940_DMA_AUTO_REINIT_EN
    , S_REINIT
`endif
  } state_e;

endpackage

// File: rtl/am2940_dma_tally.sv
// rtl/am2940_dma_tally.sv - acknowledged-word tally with last-word and done-mismatch compare.
module am2940_dma_tally
  import am2940_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             done_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             last_o,
  output logic             mismatch_o
);

  logic [WIDTH-1:0] tally_q, tally_d;

  always_comb begin
    tally_d = tally_q;
    if (clr_i) begin
      tally_d = '0;
    end else if (inc_i) begin
      tally_d = tally_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tally_q <= '0;
    end else begin
      tally_q <= tally_d;
    end
  end

  // The word being acknowledged now is the last one when tally+1 reaches count.
  assign last_o     = ((tally_q + WIDTH'(1)) == count_i);
  assign mismatch_o = inc_i & (last_o ^ done_i);

endmodule

// File: rtl/am2940_dma_ctrl.sv
// rtl/am2940_dma_ctrl.sv - am2940 initiator: programs CR/address/count, then steps a block transfer.
// Define AM2940_DMA_AUTO_REINIT_EN to issue REINITIALIZE COUNTERS after a completed transfer.
module am2940_dma_ctrl
  import am2940_pkg::*;
#(
  parameter int         WIDTH      = WIDTH_DEFAULT,
  parameter logic [2:0] IDLE_INSTR = 3'b001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] ctrl_cfg,
  input  logic [WIDTH-1:0] start_addr,
  input  logic [WIDTH-1:0] word_cnt,
  input  logic             xfer_ack,
  input  logic             done,
  output logic [2:0]       instr,
  output logic [WIDTH-1:0] data_out,
  output logic             acineg,
  output logic             wcineg,
  output logic             xfer_req,
  output logic             busy,
  output logic             finished,
  output logic             error
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cfg_q, addr_q, cnt_q;
  logic             error_q, error_d;
  logic             accept, tally_inc, last_word, mismatch;

  assign accept    = (state_q == S_IDLE) && start;
  assign tally_inc = (state_q == S_XFER) && xfer_ack;

  am2940_dma_tally #(.WIDTH(WIDTH)) u_tally (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (accept),
    .inc_i     (tally_inc),
    .done_i    (done),
    .count_i   (cnt_q),
    .last_o    (last_word),
    .mismatch_o(mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      error_q <= 1'b0;
      cfg_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      if (accept) begin
        cfg_q  <= ctrl_cfg;
        addr_q <= start_addr;
        cnt_q  <= word_cnt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR_CR;
          error_d = 1'b0;
        end
      end
      S_WR_CR:   state_d = S_LD_ADDR;
      S_LD_ADDR: state_d = S_LD_WC;
      S_LD_WC:   state_d = (cnt_q == '0) ? S_FIN : S_XFER;
      S_XFER: begin
        // done is only meaningful alongside an acknowledged word.
        if (mismatch) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else if (xfer_ack && done && last_word) begin
`ifdef AM2940_DMA_AUTO_REINIT_EN
          state_d = S_REINIT;
`else
          state_d = S_FIN;
`endif
        end
      end
`ifdef AM2940_DMA_AUTO_REINIT_EN
      S_REINIT:  state_d = S_FIN;
`endif
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      error_d = error_q;
    end
  end

  always_comb begin
    instr    = IDLE_INSTR;
    data_out = '0;
    xfer_req = 1'b0;
    finished = 1'b0;
    case (state_q)
      S_WR_CR: begin
        instr    = WRCR;
        data_out = cfg_q;
      end
      S_LD_ADDR: begin
        instr    = LDAD;
        data_out = addr_q;
      end
      S_LD_WC: begin
        instr    = LDWC;
        data_out = cnt_q;
      end
      S_XFER: begin
        instr    = ENCT;
        xfer_req = 1'b1;
      end
`ifdef AM2940_DMA_AUTO_REINIT_EN
      S_REINIT:  instr = REINIT;
`endif
      S_FIN:     finished = 1'b1;
      default:   instr = IDLE_INSTR;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign acineg = ~tally_inc;
  assign wcineg = ~tally_inc;
  assign error  = error_q;

endmodule

// File: tb/tb_am2940_dma_ctrl.sv
// tb/tb_am2940_dma_ctrl.sv - directed cycle tables for am2940_dma_ctrl; honours AM2940_DMA_AUTO_REINIT_EN.
module tb_am2940_dma_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, xfer_ack, done;
  logic [7:0] ctrl_cfg, start_addr, word_cnt;
  logic [2:0] instr;
  logic [7:0] data_out;
  logic       acineg, wcineg, xfer_req, busy, finished, error;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rs;
    logic        st;
    logic        ab;
    logic        ack;
    logic        dn;
    logic [16:0] exp;
  } vec_t;

  am2940_dma_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .ctrl_cfg  (ctrl_cfg),
    .start_addr(start_addr),
    .word_cnt  (word_cnt),
    .xfer_ack  (xfer_ack),
    .done      (done),
    .instr     (instr),
    .data_out  (data_out),
    .acineg    (acineg),
    .wcineg    (wcineg),
    .xfer_req  (xfer_req),
    .busy      (busy),
    .finished  (finished),
    .error     (error)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {instr, data_out, acineg, wcineg, xfer_req, busy, finished, error};

  // Expected output word: {instr, data_out, acineg, wcineg, xfer_req, busy, finished, error}
  function automatic logic [16:0] e_idle(input logic e);
    return {3'b001, 8'h00, 5'b11000, e};
  endfunction
  function automatic logic [16:0] e_wr(input logic [7:0] d, input logic e);
    return {3'b000, d, 5'b11010, e};
  endfunction
  function automatic logic [16:0] e_la(input logic [7:0] d, input logic e);
    return {3'b101, d, 5'b11010, e};
  endfunction
  function automatic logic [16:0] e_lw(input logic [7:0] d, input logic e);
    return {3'b110, d, 5'b11010, e};
  endfunction
  function automatic logic [16:0] e_x(input logic ack, input logic e);
    return {3'b111, 8'h00, ~ack, ~ack, 3'b110, e};
  endfunction
  function automatic logic [16:0] e_ri(input logic e);
    return {3'b100, 8'h00, 5'b11010, e};
  endfunction
  function automatic logic [16:0] e_fin();
    return {3'b001, 8'h00, 6'b110110};
  endfunction
  function automatic vec_t mk(input logic rs, st, ab, ack, dn, input logic [16:0] exp);
    return '{rs: rs, st: st, ab: ab, ack: ack, dn: dn, exp: exp};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== e_idle(1'b0)) begin
      errors++;
      $display("FAIL reset: got %05h expected %05h", obs, e_idle(1'b0));
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs !== e_idle(1'b0)) begin
      errors++;
      $display("FAIL reset_hold_start: got %05h expected %05h", obs, e_idle(1'b0));
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec_t v[$];
    ctrl_cfg = 8'h01; start_addr = 8'h66; word_cnt = 8'h03;
    v.push_back(mk(0, 1, 0, 0, 0, e_idle(0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_wr(8'h01, 0)));
    v.push_back(mk(0, 1, 0, 0, 0, e_la(8'h66, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_lw(8'h03, 0)));
    v.push_back(mk(0, 0, 0, 1, 0, e_x(1, 0)));
    v.push_back(mk(0, 0, 0, 1, 0, e_x(1, 0)));
    v.push_back(mk(0, 0, 0, 1, 1, e_x(1, 0)));
`ifdef AM2940_DMA_AUTO_REINIT_EN
    v.push_back(mk(0, 0, 0, 0, 0, e_ri(0)));
`endif
    v.push_back(mk(0, 0, 0, 0, 0, e_fin()));
    v.push_back(mk(0, 0, 0, 0, 0, e_idle(0)));
    foreach (v[i]) begin
      rst = v[i].rs; start = v[i].st; abort = v[i].ab; xfer_ack = v[i].ack; done = v[i].dn;
      if (i == 1) begin
        ctrl_cfg = 8'hEE; start_addr = 8'hEE; word_cnt = 8'h07;
      end
      #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL basic[%0d]: got %05h expected %05h", i, obs, v[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_count();
    vec_t v[$];
    ctrl_cfg = 8'h5A; start_addr = 8'h10; word_cnt = 8'h00;
    v.push_back(mk(0, 1, 0, 0, 0, e_idle(0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_wr(8'h5A, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_la(8'h10, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_lw(8'h00, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_fin()));
    v.push_back(mk(0, 0, 0, 0, 0, e_idle(0)));
    foreach (v[i]) begin
      rst = v[i].rs; start = v[i].st; abort = v[i].ab; xfer_ack = v[i].ack; done = v[i].dn;
      #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL zero_count[%0d]: got %05h expected %05h", i, obs, v[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stalled_acks();
    vec_t v[$];
    ctrl_cfg = 8'h02; start_addr = 8'h20; word_cnt = 8'h02;
    v.push_back(mk(0, 1, 0, 0, 0, e_idle(0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_wr(8'h02, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_la(8'h20, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_lw(8'h02, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_x(0, 0)));
    v.push_back(mk(0, 0, 0, 1, 0, e_x(1, 0)));
    v.push_back(mk(0, 0, 0, 0, 1, e_x(0, 0)));
    v.push_back(mk(0, 0, 0, 1, 1, e_x(1, 0)));
`ifdef AM2940_DMA_AUTO_REINIT_EN
    v.push_back(mk(0, 0, 0, 0, 0, e_ri(0)));
`endif
    v.push_back(mk(0, 0, 0, 0, 0, e_fin()));
    v.push_back(mk(0, 0, 0, 0, 0, e_idle(0)));
    foreach (v[i]) begin
      rst = v[i].rs; start = v[i].st; abort = v[i].ab; xfer_ack = v[i].ack; done = v[i].dn;
      #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL stalled[%0d]: got %05h expected %05h", i, obs, v[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mismatch();
    vec_t v[$];
    ctrl_cfg = 8'h03; start_addr = 8'h30; word_cnt = 8'h02;
    v.push_back(mk(0, 1, 0, 0, 0, e_idle(0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_wr(8'h03, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_la(8'h30, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_lw(8'h02, 0)));
    v.push_back(mk(0, 0, 0, 1, 1, e_x(1, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_idle(1)));
    foreach (v[i]) begin
      rst = v[i].rs; start = v[i].st; abort = v[i].ab; xfer_ack = v[i].ack; done = v[i].dn;
      #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL early_done[%0d]: got %05h expected %05h", i, obs, v[i].exp);
      end
      @(negedge clk);
    end
    v.delete();
    word_cnt = 8'h01;
    v.push_back(mk(0, 1, 0, 0, 0, e_idle(1)));
    v.push_back(mk(0, 0, 0, 0, 0, e_wr(8'h03, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_la(8'h30, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_lw(8'h01, 0)));
    v.push_back(mk(0, 0, 0, 1, 0, e_x(1, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_idle(1)));
    v.push_back(mk(0, 0, 0, 0, 0, e_idle(1)));
    foreach (v[i]) begin
      rst = v[i].rs; start = v[i].st; abort = v[i].ab; xfer_ack = v[i].ack; done = v[i].dn;
      #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL missing_done[%0d]: got %05h expected %05h", i, obs, v[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    vec_t v[$];
    ctrl_cfg = 8'h04; start_addr = 8'h40; word_cnt = 8'h03;
    v.push_back(mk(0, 1, 0, 0, 0, e_idle(1)));
    v.push_back(mk(0, 0, 0, 0, 0, e_wr(8'h04, 0)));
    v.push_back(mk(0, 0, 1, 0, 0, e_la(8'h40, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_idle(0)));
    v.push_back(mk(0, 1, 0, 0, 0, e_idle(0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_wr(8'h04, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_la(8'h40, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_lw(8'h03, 0)));
    v.push_back(mk(0, 0, 0, 1, 0, e_x(1, 0)));
    v.push_back(mk(0, 1, 1, 1, 1, e_x(1, 0)));
    v.push_back(mk(0, 0, 0, 1, 0, e_idle(0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_idle(0)));
    foreach (v[i]) begin
      rst = v[i].rs; start = v[i].st; abort = v[i].ab; xfer_ack = v[i].ack; done = v[i].dn;
      #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL abort[%0d]: got %05h expected %05h", i, obs, v[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_xfer();
    vec_t v[$];
    ctrl_cfg = 8'h05; start_addr = 8'h50; word_cnt = 8'h03;
    v.push_back(mk(0, 1, 0, 0, 0, e_idle(0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_wr(8'h05, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_la(8'h50, 0)));
    v.push_back(mk(0, 0, 0, 0, 0, e_lw(8'h03, 0)));
    v.push_back(mk(0, 0, 0, 1, 0, e_x(1, 0)));
    v.push_back(mk(1, 0, 0, 1, 0, e_x(1, 0)));
    v.push_back(mk(0, 0, 0, 1, 0, e_idle(0)));
    v.push_back(mk(0, 0, 0, 1, 1, e_idle(0)));
    foreach (v[i]) begin
      rst = v[i].rs; start = v[i].st; abort = v[i].ab; xfer_ack = v[i].ack; done = v[i].dn;
      #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %05h expected %05h", i, obs, v[i].exp);
      end
      @(negedge clk);
    end
    xfer_ack = 1'b0;
    done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; xfer_ack = 1'b0; done = 1'b0;
    ctrl_cfg = 8'h00; start_addr = 8'h00; word_cnt = 8'h00;
    test_reset();
    test_basic();
    test_zero_count();
    test_stalled_acks();
    test_mismatch();
    test_abort();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
